// File: rtl/bus_ctrl.sv
// ---------------------------------------------------------------------------
// bus_ctrl - single-master, multi-slave peripheral bus controller.
//
// Decodes the CPU address into one of N_SLV slave regions, drives a shared
// address / write-data / write-enable plus a one-hot slave select, waits for
// the selected slave's ack and returns a one-cycle ready pulse to the CPU.
// Unmapped addresses end with an error response. When BUS_TIMEOUT_EN is
// defined, a slave that fails to ack within TIMEOUT cycles is aborted and
// also answered with an error.
//
// Optional feature macro: BUS_TIMEOUT_EN (access timeout counter).
//
// Ports:
//   clk          bus clock, rising edge
//   rst_n        asynchronous active-low reset
//   cpu_req_i    transfer request (sampled only in IDLE)
//   cpu_we_i     1 = write, 0 = read
//   cpu_addr_i   transfer address
//   cpu_data_i   write data
//   cpu_data_o   read data, qualified by cpu_ready_o
//   cpu_ready_o  one-cycle transfer-complete pulse
//   cpu_err_o    error qualifier, valid with cpu_ready_o
//   per_addr_o   latched address shared by all slaves
//   per_data_o   latched write data shared by all slaves
//   per_we_o     latched write enable
//   per_sel_o    one-hot slave select
//   per_data_i   slave read data, slave k on [k*DATA_W +: DATA_W]
//   per_ack_i    slave acknowledge, one bit per slave
// ---------------------------------------------------------------------------
module bus_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int N_SLV      = 4,
   parameter int REGION_LSB = 12,
   parameter int TIMEOUT    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cpu_req_i,
   input  logic                    cpu_we_i,
   input  logic [ADDR_W-1:0]       cpu_addr_i,
   input  logic [DATA_W-1:0]       cpu_data_i,
   output logic [DATA_W-1:0]       cpu_data_o,
   output logic                    cpu_ready_o,
   output logic                    cpu_err_o,
   output logic [ADDR_W-1:0]       per_addr_o,
   output logic [DATA_W-1:0]       per_data_o,
   output logic                    per_we_o,
   output logic [N_SLV-1:0]        per_sel_o,
   input  logic [N_SLV*DATA_W-1:0] per_data_i,
   input  logic [N_SLV-1:0]        per_ack_i
);

   localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
   localparam logic [SEL_W:0] N_SLV_C = (SEL_W + 1)'(N_SLV);

   // Elaboration-time parameter sanity checks.
   if (N_SLV < 2 || N_SLV > 16) begin : g_bad_nslv
      $error("bus_ctrl: N_SLV must be in 2..16");
   end
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("bus_ctrl: TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]          cnt_q, cnt_d;
`endif

   logic [N_SLV-1:0]    sel_dec;
   logic                ack_hit;
   logic [DATA_W-1:0]   rd_mux;
   logic [SEL_W-1:0]    idx_in;

   assign idx_in = cpu_addr_i[REGION_LSB +: SEL_W];

   // One-hot decode of the latched index; out-of-range indices decode to 0.
   for (genvar gi = 0; gi < N_SLV; gi++) begin : g_dec
      assign sel_dec[gi] = (idx_q == SEL_W'(gi));
   end

   // Only the selected slave's ack counts; strays from others are masked.
   assign ack_hit = |(per_ack_i & sel_dec);

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (sel_dec[i]) rd_mux = per_data_i[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      idx_d   = idx_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef BUS_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (cpu_req_i) begin
               addr_d  = cpu_addr_i;
               wdata_d = cpu_data_i;
               we_d    = cpu_we_i;
               idx_d   = idx_in;
               if ({1'b0, idx_in} < N_SLV_C) begin
                  state_d = ACCESS;
`ifdef BUS_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  // Decode miss: answer immediately with an error.
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         ACCESS: begin
            // Ack takes priority over a timeout expiring in the same cycle.
            if (ack_hit) begin
               rdata_d = we_q ? '0 : rd_mux;
               err_d   = 1'b0;
               state_d = RESP;
            end
`ifdef BUS_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef BUS_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign per_sel_o   = (state_q == ACCESS) ? sel_dec : '0;
   assign cpu_ready_o = (state_q == RESP);
   assign cpu_err_o   = (state_q == RESP) && err_q;
   assign cpu_data_o  = rdata_q;
   assign per_addr_o  = addr_q;
   assign per_data_o  = wdata_q;
   assign per_we_o    = we_q;

endmodule
